// File: rtl/writeback_regfile_pipe_pkg.sv
// Shared constants and types for the writeback stage: status codes, instruction
// codes, register IDs, the W pipeline-register layout and the control states.
package writeback_regfile_pipe_pkg;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         NUM_REGS = 15;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_entry_t;

    // Canonical NOP bubble: harmless status, no destinations, zero data.
    function automatic w_entry_t bubble_entry();
        w_entry_t e;
        e.stat  = STAT_AOK;
        e.icode = I_NOP;
        e.val_e = 64'h0;
        e.val_m = 64'h0;
        e.dst_e = RNONE;
        e.dst_m = RNONE;
        return e;
    endfunction

endpackage

// File: rtl/writeback_regfile_pipe_regfile_pipe.sv
// Fifteen-entry 64-bit register file with two write ports (E and M, M wins on
// collision) and two combinational read ports that forward in-flight writes.
module regfile_pipe
    import writeback_regfile_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b,
    output logic [63:0] rsp
);

    logic [63:0] regs_r [NUM_REGS];
    logic        we_e_s;
    logic        we_m_s;
    logic [63:0] stored_a_s;
    logic [63:0] stored_b_s;

    // Resolve one read port: RNONE reads zero, M forwarding beats E forwarding.
    function automatic logic [63:0] read_port(
        input logic [3:0]  src,
        input logic [63:0] stored,
        input logic        wr_e,
        input logic [3:0]  wr_dst_e,
        input logic [63:0] wr_val_e,
        input logic        wr_m,
        input logic [3:0]  wr_dst_m,
        input logic [63:0] wr_val_m
    );
        logic [63:0] r;
        if (src == RNONE) begin
            r = 64'h0;
        end else if (wr_m && (wr_dst_m == src)) begin
            r = wr_val_m;
        end else if (wr_e && (wr_dst_e == src)) begin
            r = wr_val_e;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Per-port write enables; RNONE is never a real destination.
    always_comb begin
        we_e_s = we && (dst_e != RNONE);
        we_m_s = we && (dst_m != RNONE);
    end

    // Stored values for each read port, guarding the out-of-range RNONE index.
    always_comb begin
        stored_a_s = 64'h0;
        stored_b_s = 64'h0;
        if (src_a != RNONE) begin
            stored_a_s = regs_r[src_a];
        end else begin
            stored_a_s = 64'h0;
        end
        if (src_b != RNONE) begin
            stored_b_s = regs_r[src_b];
        end else begin
            stored_b_s = 64'h0;
        end
    end

    // Forwarding read ports.
    always_comb begin
        rval_a = read_port(src_a, stored_a_s, we_e_s, dst_e, val_e, we_m_s, dst_m, val_m);
        rval_b = read_port(src_b, stored_b_s, we_e_s, dst_e, val_e, we_m_s, dst_m, val_m);
    end

    assign rsp = regs_r[REG_RSP];

    // Register storage; the M write is issued last so it wins a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 64'h0;
            end
        end else begin
            if (we_e_s) begin
                regs_r[dst_e] <= val_e;
            end
            if (we_m_s) begin
                regs_r[dst_m] <= val_m;
            end
        end
    end

endmodule

// File: rtl/writeback_regfile_pipe.sv
// Writeback stage: W pipeline register, RUN/HALT control, retired-instruction
// counter, and the register file that W commits into.
module writeback_regfile_pipe
    import writeback_regfile_pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        W_stall_i,
    input  logic        W_bubble_i,
    input  logic [3:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] m_valM_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    output logic [63:0] d_rvalA_o,
    output logic [63:0] d_rvalB_o,
    output logic [3:0]  W_stat_o,
    output logic [3:0]  W_icode_o,
    output logic [63:0] W_valE_o,
    output logic [63:0] W_valM_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o,
    output logic        halt_o,
    output logic [63:0] instret_o,
    output logic [63:0] rsp_o
);

    w_entry_t    w_r;
    w_entry_t    m_entry_s;
    ctrl_state_t state_r;
    logic        halt_r;
    logic [63:0] instret_r;
    logic        commit_s;
    logic        retire_s;

    // Pack memory-stage results and derive commit/retire qualifiers.
    always_comb begin
        m_entry_s.stat  = M_stat_i;
        m_entry_s.icode = M_icode_i;
        m_entry_s.val_e = M_valE_i;
        m_entry_s.val_m = m_valM_i;
        m_entry_s.dst_e = M_dstE_i;
        m_entry_s.dst_m = M_dstM_i;
        commit_s = (state_r == ST_RUN) && (w_r.stat == STAT_AOK);
        retire_s = commit_s && (w_r.icode != I_NOP);
    end

    // W pipeline register: halt freezes it, stall outranks bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_r <= bubble_entry();
        end else if (state_r == ST_HALT) begin
            w_r <= w_r;
        end else if (W_stall_i) begin
            w_r <= w_r;
        end else if (W_bubble_i) begin
            w_r <= bubble_entry();
        end else begin
            w_r <= m_entry_s;
        end
    end

    // Control FSM with registered halt flag and retire counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_RUN;
            halt_r    <= 1'b0;
            instret_r <= 64'h0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (w_r.stat != STAT_AOK) begin
                        state_r <= ST_HALT;
                        halt_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        halt_r  <= 1'b0;
                    end
                    if (retire_s) begin
                        instret_r <= instret_r + 64'd1;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_HALT;
                    halt_r  <= 1'b1;
                end
            endcase
        end
    end

    regfile_pipe u_regfile (
        .clk    (clk_i),
        .rst    (rst_i),
        .we     (commit_s),
        .dst_e  (w_r.dst_e),
        .val_e  (w_r.val_e),
        .dst_m  (w_r.dst_m),
        .val_m  (w_r.val_m),
        .src_a  (d_srcA_i),
        .src_b  (d_srcB_i),
        .rval_a (d_rvalA_o),
        .rval_b (d_rvalB_o),
        .rsp    (rsp_o)
    );

    assign W_stat_o  = w_r.stat;
    assign W_icode_o = w_r.icode;
    assign W_valE_o  = w_r.val_e;
    assign W_valM_o  = w_r.val_m;
    assign W_dstE_o  = w_r.dst_e;
    assign W_dstM_o  = w_r.dst_m;
    assign halt_o    = halt_r;
    assign instret_o = instret_r;

endmodule

// File: doc/writeback_regfile_pipe.md
WRITEBACK_REGFILE_PIPE -- requirements
Module: writeback_regfile_pipe

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: W_stall_i  in  1  hold W register; W_bubble_i  in  1  load NOP bubble into W register.
REQ-004 SHALL have ports: M_stat_i  in  4, M_icode_i  in  4, M_valE_i  in  64, m_valM_i  in  64, M_dstE_i  in  4, M_dstM_i  in  4  memory-stage results.
REQ-005 SHALL have ports: d_srcA_i  in  4, d_srcB_i  in  4  decode read addresses; d_rvalA_o  out  64, d_rvalB_o  out  64  read data.
REQ-006 SHALL have ports: W_stat_o  out  4, W_icode_o  out  4, W_valE_o  out  64, W_valM_o  out  64, W_dstE_o  out  4, W_dstM_o  out  4  W register contents.
REQ-007 SHALL have ports: halt_o  out  1  sticky halted flag; instret_o  out  64  retired-instruction count; rsp_o  out  64  current %rsp (reg 4).

Function
REQ-008 W register SHALL capture all M inputs on rising edge when W_stall_i=0 and W_bubble_i=0.
REQ-009 W_stall_i=1 SHALL hold W register unchanged; stall SHALL take priority over bubble when both asserted.
REQ-010 W_bubble_i=1 (no stall) SHALL load stat=AOK(1), icode=NOP(1), dstE=dstM=RNONE(F), valE=valM=0.
REQ-011 Register file SHALL hold 15 x 64-bit registers, IDs 0..E; ID F (RNONE) SHALL never be written.
REQ-012 On each rising edge, while in RUN and W_stat_o=AOK, SHALL write W_valE_o to W_dstE_o and W_valM_o to W_dstM_o (each skipped when F).
REQ-013 When W_dstE_o=W_dstM_o!=F, valM write SHALL win.
REQ-014 Reads SHALL be combinational; source F SHALL return 0.
REQ-015 Reads SHALL be write-through: if a source matches a register being written this cycle, SHALL return the value being written (valM precedence per REQ-013).
REQ-016 Control FSM SHALL have states RUN and HALT; reset enters RUN.
REQ-017 RUN->HALT SHALL occur on the rising edge at which W_stat_o holds any non-AOK code (HLT=2, ADR=3, INS=4); register writes from that W entry SHALL be suppressed.
REQ-018 In HALT: W register SHALL freeze regardless of stall/bubble, no register writes, halt_o=1; only reset exits HALT.
REQ-019 instret_o SHALL increment by 1 on each rising edge in RUN where W_stat_o=AOK and W_icode_o!=NOP; SHALL wrap modulo 2^64.
REQ-020 rsp_o SHALL equal register 4 contents (no write-through).
REQ-021 Reads SHALL remain valid during HALT (return frozen file contents).

Reset
REQ-022 rst_i=1 SHALL asynchronously clear all 15 registers to 0, instret_o to 0, halt_o to 0, FSM to RUN.
REQ-023 rst_i=1 SHALL load W register with bubble values per REQ-010.
REQ-024 Reset asserted mid-write SHALL discard the pending write; first write occurs on first rising edge after rst_i deasserts.

Structure
REQ-025 icode constants (NOP etc.), RNONE, register IDs (RSP=4), and stat codes (AOK, HLT, ADR, INS) SHALL live in shared define.v.
REQ-026 Register file with two write ports, two write-through read ports SHALL be sub-module regfile_pipe; W register, FSM, counter in top.

Verification
REQ-027 Bubble after reset: rst_i pulse, then 3 edges with W_bubble_i=1 -> W_icode_o=1, W_dstE_o=F, instret_o=0, halt_o=0.
REQ-028 Single write/read: M_icode=3, M_dstE=2, M_valE=0x1234 captured, next edge writes -> d_srcA_i=2 gives 0x1234; same-cycle read gives 0x1234 via write-through.
REQ-029 Dual write conflict: dstE=dstM=4, valE=0x10, valM=0x20 -> reg4=0x20, rsp_o=0x20.
REQ-030 Stall priority: W_stall_i=1 and W_bubble_i=1 with W holding icode=3 -> W contents unchanged, instret_o increments each edge W is AOK non-NOP.
REQ-031 Halt: M_stat=HLT, dstE=1, valE=0xFF -> halt_o=1, reg1 unchanged (0), further M inputs ignored, instret_o frozen; rst_i restores RUN and zeros.
REQ-032 RNONE: dstE=F, valE=0xDEAD -> no register changes; d_srcB_i=F returns 0.
